damage_dispatcher: RTL and testbench
====================================

DAMAGE_DISPATCHER -- requirements
Module: damage_dispatcher

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 16: unit slots per side (>=2).
REQ-002 SHALL have parameter IN_W, default 12: raw damage width.
REQ-003 SHALL have parameter DMG_W, default 8: applied damage width, DMG_W < IN_W.
REQ-004 SHALL have parameter DEPTH, default 4: per-channel queue depth, power of 2, >=2.
REQ-005 SHALL derive SEL_W = clog2(NUM_UNITS)+1 and CNT_W = clog2(DEPTH)+1.
REQ-006 SHALL have ports:
  Clk  in  1  sole clock, rising edge
  Reset_n  in  1  synchronous active-low reset
  Enable  in  1  dispatch permitted this cycle (game tick)
  unitReqValid  in  1  damage-to-friendly request valid
  unitReqReady  out  1  unit queue can accept
  unitReqSelect  in  SEL_W  target; >=NUM_UNITS means friendly tower
  unitReqDamage  in  IN_W  raw damage
  enemyReqValid / enemyReqReady / enemyReqSelect / enemyReqDamage  same as unit*, enemy side
  unitAppliedDamage  out  NUM_UNITS*DMG_W  slot i at [i*DMG_W +: DMG_W]
  friendlyTowerAppliedDamage  out  DMG_W  tower damage
  unitApplyStrobe  out  1  unit-side outputs valid this cycle
  enemyAppliedDamage / enemyTowerAppliedDamage / enemyApplyStrobe  same, enemy side
  unitQueueCount / enemyQueueCount  out  CNT_W  entries held

Function
REQ-007 SHALL treat the two channels identically and independently; no shared state.
REQ-008 SHALL accept a request on a cycle where Valid && Ready; Ready = (count < DEPTH), registered-state only, not dependent on same-cycle pop.
REQ-009 SHALL saturate on acceptance: stored damage = (raw >= 2^DMG_W) ? all-ones : raw[DMG_W-1:0].
REQ-010 SHALL store accepted entries in FIFO order {select, damage}; pointers wrap modulo DEPTH.
REQ-011 SHALL pop the head entry on a cycle where Enable=1 and count>0, at most one per channel per cycle.
REQ-012 SHALL, the cycle after a pop, drive Strobe=1, the selected slot (or tower if select>=NUM_UNITS) = stored damage, all other slots and tower = 0.
REQ-013 SHALL drive all applied outputs and Strobe = 0 in every cycle not following a pop; outputs are registered.
REQ-014 SHALL give minimum latency 2 cycles from acceptance edge to Strobe (accept in cycle N, pop in N+1, Strobe in N+2).
REQ-015 SHALL on simultaneous push and pop update count by 0; push into full queue is impossible (Ready=0).
REQ-016 SHALL ignore Valid while Ready=0; Select/Damage are don't-care when Valid=0.
REQ-017 SHALL hold queue contents while Enable=0.

Reset
REQ-018 SHALL, on Clk edge with Reset_n=0, clear pointers and counts to 0, all applied outputs and Strobes to 0, Ready to 1 after release.
REQ-019 SHALL discard queued entries and any pending strobe on reset asserted mid-operation; no output for them after release.

Configuration
REQ-020 SHALL support macro DAMAGE_MERGE_EN.
REQ-021 SHALL with DAMAGE_MERGE_EN defined: an accepted request whose select equals the tail entry's select (count>0, tail not being popped this cycle) adds saturating into the tail damage instead of pushing; count unchanged; Ready still = (count < DEPTH).
REQ-022 SHALL without DAMAGE_MERGE_EN: every accepted request occupies its own entry.

Verification
REQ-023 SHALL test: reset, unit request sel=3 dmg=0x050, Enable=1 -> 2 cycles later unitApplyStrobe=1, slot 3=0x50, others/tower 0, one cycle only.
REQ-024 SHALL test: enemy request sel=16 dmg=0x1A0 -> enemyTowerAppliedDamage=0xFF, all enemy slots 0.
REQ-025 SHALL test: Enable=0, push 4 unit requests -> unitReqReady=0, count=4; 5th Valid ignored; Enable=1 -> 4 strobes in FIFO order on consecutive cycles.
REQ-026 SHALL test: queue full, Reset_n=0 one cycle -> count=0, Ready=1, no strobe after release.
REQ-027 SHALL test: DAMAGE_MERGE_EN, Enable=0, push sel=2 dmg=0xC0 then sel=2 dmg=0x80 -> count=1; Enable=1 -> slot 2=0xFF single strobe; without macro count=2, two strobes 0xC0, 0x80.
REQ-028 SHALL test: both channels active same cycles with Enable toggling -> each channel's output sequence matches its own reference model.

Source files
------------

// File: rtl/damage_dispatcher_if.sv
// Request/response bundle for damage_dispatcher: per-side request handshake,
// applied-damage outputs and queue occupancy. Signal names match the block's
// external port names. master = request source, slave = dispatcher.
interface damage_dispatcher_if #(
    parameter int NUM_UNITS = 16,
    parameter int IN_W      = 12,
    parameter int DMG_W     = 8,
    parameter int DEPTH     = 4
);
    localparam int SEL_W = $clog2(NUM_UNITS) + 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                       unitReqValid;
    logic                       unitReqReady;
    logic [SEL_W-1:0]           unitReqSelect;
    logic [IN_W-1:0]            unitReqDamage;
    logic                       enemyReqValid;
    logic                       enemyReqReady;
    logic [SEL_W-1:0]           enemyReqSelect;
    logic [IN_W-1:0]            enemyReqDamage;
    logic [NUM_UNITS*DMG_W-1:0] unitAppliedDamage;
    logic [DMG_W-1:0]           friendlyTowerAppliedDamage;
    logic                       unitApplyStrobe;
    logic [NUM_UNITS*DMG_W-1:0] enemyAppliedDamage;
    logic [DMG_W-1:0]           enemyTowerAppliedDamage;
    logic                       enemyApplyStrobe;
    logic [CNT_W-1:0]           unitQueueCount;
    logic [CNT_W-1:0]           enemyQueueCount;

    modport master (
        output unitReqValid, unitReqSelect, unitReqDamage,
        output enemyReqValid, enemyReqSelect, enemyReqDamage,
        input  unitReqReady, enemyReqReady,
        input  unitAppliedDamage, friendlyTowerAppliedDamage, unitApplyStrobe,
        input  enemyAppliedDamage, enemyTowerAppliedDamage, enemyApplyStrobe,
        input  unitQueueCount, enemyQueueCount
    );

    modport slave (
        input  unitReqValid, unitReqSelect, unitReqDamage,
        input  enemyReqValid, enemyReqSelect, enemyReqDamage,
        output unitReqReady, enemyReqReady,
        output unitAppliedDamage, friendlyTowerAppliedDamage, unitApplyStrobe,
        output enemyAppliedDamage, enemyTowerAppliedDamage, enemyApplyStrobe,
        output unitQueueCount, enemyQueueCount
    );
endinterface

// File: rtl/damage_dispatcher.sv
// Damage dispatcher: two independent queues (friendly-unit side, enemy side)
// that accept saturated damage requests and release at most one per channel
// per enabled game tick as a one-cycle registered strobe with a one-hot slot.
// Optional feature: define DAMAGE_MERGE_EN to fold a request into the queue
// tail when it targets the same slot as the tail entry.

module damage_dispatcher_channel #(
    parameter int NUM_UNITS = 16,
    parameter int IN_W      = 12,
    parameter int DMG_W     = 8,
    parameter int DEPTH     = 4,
    parameter int SEL_W     = 5,
    parameter int CNT_W     = 3
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       Enable,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [SEL_W-1:0]           req_select,
    input  logic [IN_W-1:0]            req_damage,
    output logic [NUM_UNITS*DMG_W-1:0] applied,
    output logic [DMG_W-1:0]           tower,
    output logic                       strobe,
    output logic [CNT_W-1:0]           count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = SEL_W + DMG_W;

    logic [ENT_W-1:0]           mem_q [DEPTH];
    logic [ENT_W-1:0]           mem_d [DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [NUM_UNITS*DMG_W-1:0] applied_q, applied_d;
    logic [DMG_W-1:0]           tower_q, tower_d;
    logic                       strobe_q, strobe_d;

    logic                       push, pop, merge, grow;
    logic [DMG_W-1:0]           sat_dmg;
    logic [SEL_W-1:0]           head_sel;
    logic [DMG_W-1:0]           head_dmg;

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign req_ready = (count_q < CNT_W'(DEPTH));
    assign push      = req_valid & req_ready;
    assign pop       = Enable & (count_q != '0);
    assign sat_dmg   = (|req_damage[IN_W-1:DMG_W]) ? {DMG_W{1'b1}} : req_damage[DMG_W-1:0];
    assign {head_sel, head_dmg} = mem_q[rd_ptr_q];

`ifdef DAMAGE_MERGE_EN
    logic [SEL_W-1:0]           tail_sel;
    logic [DMG_W-1:0]           tail_dmg;
    logic [DMG_W:0]             merge_sum;
    logic [DMG_W-1:0]           merge_dmg;

    assign {tail_sel, tail_dmg} = mem_q[wr_ptr_q - PTR_W'(1)];
    assign merge_sum = {1'b0, tail_dmg} + {1'b0, sat_dmg};
    assign merge_dmg = merge_sum[DMG_W] ? {DMG_W{1'b1}} : merge_sum[DMG_W-1:0];
    // The tail is only leaving this cycle when it is also the head (count==1).
    assign merge = push && (count_q != '0) && (tail_sel == req_select)
                   && !(pop && (count_q == CNT_W'(1)));
`else
    assign merge = 1'b0;
`endif

    assign grow = push & ~merge;

    // Queue storage, pointers and occupancy for next cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (grow) begin
            mem_d[wr_ptr_q] = {req_select, sat_dmg};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
`ifdef DAMAGE_MERGE_EN
        if (merge) begin
            mem_d[wr_ptr_q - PTR_W'(1)] = {tail_sel, merge_dmg};
        end
`endif
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (grow && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !grow) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Decode the popped head into a one-hot slot/tower pattern for next cycle.
    always_comb begin
        applied_d = '0;
        tower_d   = '0;
        strobe_d  = pop;
        if (pop) begin
            if (head_sel >= SEL_W'(NUM_UNITS)) begin
                tower_d = head_dmg;
            end else begin
                for (int i = 0; i < NUM_UNITS; i++) begin
                    if (head_sel == SEL_W'(i)) begin
                        applied_d[i*DMG_W +: DMG_W] = head_dmg;
                    end
                end
            end
        end
    end

    // State registers; reset drops queued entries and any pending strobe.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            applied_q <= '0;
            tower_q   <= '0;
            strobe_q  <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            applied_q <= applied_d;
            tower_q   <= tower_d;
            strobe_q  <= strobe_d;
        end
    end

    assign applied = applied_q;
    assign tower   = tower_q;
    assign strobe  = strobe_q;
    assign count   = count_q;
endmodule

module damage_dispatcher #(
    parameter int NUM_UNITS = 16,
    parameter int IN_W      = 12,
    parameter int DMG_W     = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Enable,
    damage_dispatcher_if.slave   bus
);
    localparam int SEL_W = $clog2(NUM_UNITS) + 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    damage_dispatcher_channel #(
        .NUM_UNITS(NUM_UNITS), .IN_W(IN_W), .DMG_W(DMG_W),
        .DEPTH(DEPTH), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) u_unit (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Enable     (Enable),
        .req_valid  (bus.unitReqValid),
        .req_ready  (bus.unitReqReady),
        .req_select (bus.unitReqSelect),
        .req_damage (bus.unitReqDamage),
        .applied    (bus.unitAppliedDamage),
        .tower      (bus.friendlyTowerAppliedDamage),
        .strobe     (bus.unitApplyStrobe),
        .count      (bus.unitQueueCount)
    );

    damage_dispatcher_channel #(
        .NUM_UNITS(NUM_UNITS), .IN_W(IN_W), .DMG_W(DMG_W),
        .DEPTH(DEPTH), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) u_enemy (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Enable     (Enable),
        .req_valid  (bus.enemyReqValid),
        .req_ready  (bus.enemyReqReady),
        .req_select (bus.enemyReqSelect),
        .req_damage (bus.enemyReqDamage),
        .applied    (bus.enemyAppliedDamage),
        .tower      (bus.enemyTowerAppliedDamage),
        .strobe     (bus.enemyApplyStrobe),
        .count      (bus.enemyQueueCount)
    );
endmodule

// File: tb/tb_damage_dispatcher.sv
// Scoreboard bench for damage_dispatcher: directed stimulus pushes
// hand-computed {select, damage} expectations per side; monitors pop and
// compare whenever a side strobes, and check idle outputs are zero otherwise.
module tb_damage_dispatcher;
    localparam int NUM_UNITS = 16;
    localparam int IN_W      = 12;
    localparam int DMG_W     = 8;
    localparam int DEPTH     = 4;

    typedef struct {
        int sel;
        int dmg;
    } exp_t;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    logic Enable  = 1'b0;

    int checks = 0;
    int errors = 0;

    exp_t unit_exp[$];
    exp_t enemy_exp[$];

    damage_dispatcher_if #(.NUM_UNITS(NUM_UNITS), .IN_W(IN_W), .DMG_W(DMG_W), .DEPTH(DEPTH)) bus();

    damage_dispatcher #(.NUM_UNITS(NUM_UNITS), .IN_W(IN_W), .DMG_W(DMG_W), .DEPTH(DEPTH)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Enable  (Enable),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_apply(string side, exp_t e, logic [NUM_UNITS*DMG_W-1:0] units,
                               logic [DMG_W-1:0] tower);
        logic [NUM_UNITS*DMG_W-1:0] eu;
        logic [DMG_W-1:0]           et;
        eu = '0;
        et = '0;
        if (e.sel < NUM_UNITS) eu[e.sel*DMG_W +: DMG_W] = DMG_W'(e.dmg);
        else                   et = DMG_W'(e.dmg);
        checks++;
        if (units !== eu || tower !== et) begin
            errors++;
            $display("FAIL %s_apply sel=%0d: got slots=%h tower=%h, expected slots=%h tower=%h",
                     side, e.sel, units, tower, eu, et);
        end else begin
            $display("%s strobe sel=%0d dmg=%02h ok", side, e.sel, e.dmg);
        end
    endtask

    task automatic check_idle(string side, logic [NUM_UNITS*DMG_W-1:0] units, logic [DMG_W-1:0] tower);
        checks++;
        if (units !== '0 || tower !== '0) begin
            errors++;
            $display("FAIL %s_idle: got slots=%h tower=%h, expected all zero", side, units, tower);
        end
    endtask

    // Unit-side monitor.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (bus.unitApplyStrobe) begin
                if (unit_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unit_unexpected_strobe: got strobe with slots=%h tower=%h, expected none",
                             bus.unitAppliedDamage, bus.friendlyTowerAppliedDamage);
                end else begin
                    check_apply("unit", unit_exp.pop_front(), bus.unitAppliedDamage,
                                bus.friendlyTowerAppliedDamage);
                end
            end else begin
                check_idle("unit", bus.unitAppliedDamage, bus.friendlyTowerAppliedDamage);
            end
        end
    end

    // Enemy-side monitor.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (bus.enemyApplyStrobe) begin
                if (enemy_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL enemy_unexpected_strobe: got strobe with slots=%h tower=%h, expected none",
                             bus.enemyAppliedDamage, bus.enemyTowerAppliedDamage);
                end else begin
                    check_apply("enemy", enemy_exp.pop_front(), bus.enemyAppliedDamage,
                                bus.enemyTowerAppliedDamage);
                end
            end else begin
                check_idle("enemy", bus.enemyAppliedDamage, bus.enemyTowerAppliedDamage);
            end
        end
    end

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic unit_drive(int sel, int dmg);
        bus.unitReqValid  = 1'b1;
        bus.unitReqSelect = 5'(sel);
        bus.unitReqDamage = 12'(dmg);
    endtask

    task automatic enemy_drive(int sel, int dmg);
        bus.enemyReqValid  = 1'b1;
        bus.enemyReqSelect = 5'(sel);
        bus.enemyReqDamage = 12'(dmg);
    endtask

    initial begin
        int q_sel [4] = '{5, 9, 0, 15};
        int q_dmg [4] = '{'h011, 'h022, 'hFFF, 'h0FF};
        int q_exp [4] = '{'h11, 'h22, 'hFF, 'hFF};
        int u_sel [6] = '{1, 4, 16, 7, 20, 0};
        int u_dmg [6] = '{'h010, 'h200, 'h033, 'h0FE, 'h100, 'h0AB};
        int u_exp [6] = '{'h10, 'hFF, 'h33, 'hFE, 'hFF, 'hAB};
        int e_sel [6] = '{15, 2, 31, 2, 8, 3};
        int e_dmg [6] = '{'h001, 'h0FF, 'h7FF, 'h040, 'h080, 'h999};
        int e_exp [6] = '{'h01, 'hFF, 'hFF, 'h40, 'h80, 'hFF};

        bus.unitReqValid   = 1'b0;
        bus.unitReqSelect  = '0;
        bus.unitReqDamage  = '0;
        bus.enemyReqValid  = 1'b0;
        bus.enemyReqSelect = '0;
        bus.enemyReqDamage = '0;

        // Reset state.
        Reset_n = 1'b0;
        repeat (2) tick();
        chk("rst_unit_count", int'(bus.unitQueueCount), 0);
        chk("rst_enemy_count", int'(bus.enemyQueueCount), 0);
        chk("rst_unit_strobe", int'(bus.unitApplyStrobe), 0);
        chk("rst_enemy_strobe", int'(bus.enemyApplyStrobe), 0);
        Reset_n = 1'b1;
        tick();
        chk("rst_unit_ready", int'(bus.unitReqReady), 1);
        chk("rst_enemy_ready", int'(bus.enemyReqReady), 1);

        // Single unit request: exact two-cycle latency, one-cycle strobe.
        Enable = 1'b1;
        unit_drive(3, 'h050);
        unit_exp.push_back('{3, 'h50});
        tick();
        bus.unitReqValid = 1'b0;
        chk("lat_count_after_accept", int'(bus.unitQueueCount), 1);
        chk("lat_strobe_after_accept", int'(bus.unitApplyStrobe), 0);
        tick();
        chk("lat_strobe_two_after", int'(bus.unitApplyStrobe), 1);
        chk("lat_count_after_pop", int'(bus.unitQueueCount), 0);
        tick();
        chk("lat_strobe_single", int'(bus.unitApplyStrobe), 0);
        chk("lat_unit_drained", unit_exp.size(), 0);

        // Enemy tower request with saturation.
        enemy_drive(16, 'h1A0);
        enemy_exp.push_back('{16, 'hFF});
        tick();
        bus.enemyReqValid = 1'b0;
        repeat (3) tick();
        chk("tower_enemy_drained", enemy_exp.size(), 0);

        // Fill unit queue while disabled, reject a fifth, then drain in order.
        Enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            unit_drive(q_sel[i], q_dmg[i]);
            unit_exp.push_back('{q_sel[i], q_exp[i]});
            tick();
        end
        bus.unitReqValid = 1'b0;
        chk("full_ready", int'(bus.unitReqReady), 0);
        chk("full_count", int'(bus.unitQueueCount), 4);
        unit_drive(7, 'h077);
        tick();
        bus.unitReqValid = 1'b0;
        chk("full_fifth_ignored", int'(bus.unitQueueCount), 4);
        Enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("full_strobe_%0d", k), int'(bus.unitApplyStrobe), 1);
        end
        tick();
        chk("full_strobe_end", int'(bus.unitApplyStrobe), 0);
        chk("full_count_end", int'(bus.unitQueueCount), 0);
        chk("full_unit_drained", unit_exp.size(), 0);

        // Reset with a full queue: everything discarded.
        Enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            unit_drive(i + 1, 'h030);
            tick();
        end
        bus.unitReqValid = 1'b0;
        chk("rstfull_count_before", int'(bus.unitQueueCount), 4);
        Reset_n = 1'b0;
        Enable  = 1'b1;
        tick();
        Reset_n = 1'b1;
        chk("rstfull_count", int'(bus.unitQueueCount), 0);
        chk("rstfull_ready", int'(bus.unitReqReady), 1);
        repeat (4) tick();
        chk("rstfull_count_after", int'(bus.unitQueueCount), 0);

        // Same-slot requests: merged or kept separate depending on build.
        Enable = 1'b0;
        unit_drive(2, 'h0C0);
        tick();
        unit_drive(2, 'h080);
        tick();
        bus.unitReqValid = 1'b0;
`ifdef DAMAGE_MERGE_EN
        chk("merge_count", int'(bus.unitQueueCount), 1);
        unit_exp.push_back('{2, 'hFF});
`else
        chk("merge_count", int'(bus.unitQueueCount), 2);
        unit_exp.push_back('{2, 'hC0});
        unit_exp.push_back('{2, 'h80});
`endif
        Enable = 1'b1;
        repeat (4) tick();
        chk("merge_unit_drained", unit_exp.size(), 0);

        // Both channels busy with Enable toggling.
        for (int i = 0; i < 6; i++) begin
            Enable = (i % 2 == 0);
            unit_drive(u_sel[i], u_dmg[i]);
            enemy_drive(e_sel[i], e_dmg[i]);
            unit_exp.push_back('{u_sel[i], u_exp[i]});
            enemy_exp.push_back('{e_sel[i], e_exp[i]});
            tick();
        end
        bus.unitReqValid  = 1'b0;
        bus.enemyReqValid = 1'b0;
        Enable = 1'b1;
        repeat (8) tick();
        chk("dual_unit_drained", unit_exp.size(), 0);
        chk("dual_enemy_drained", enemy_exp.size(), 0);
        chk("dual_unit_count", int'(bus.unitQueueCount), 0);
        chk("dual_enemy_count", int'(bus.enemyQueueCount), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
